// File: rtl/gs_pkg.sv
// Shared constants, FSM encoding and coordinate clamp for the 5x5 Gaussian window fetcher.
package gs_pkg;

  localparam int KSIZE = 5;
  localparam int KTAPS = KSIZE * KSIZE;
  localparam int KRAD  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } gs_state_e;

  // Edge replication: pull a signed coordinate back into 0..hi.
  function automatic int gs_clamp(input int v, input int hi);
    if (v < 0) begin
      return 0;
    end else if (v > hi) begin
      return hi;
    end
    return v;
  endfunction

endpackage

// File: rtl/gs_win_cnt.sv
// Nested window counter: dx (innermost), dy, then output pixel x, y in raster order.
module gs_win_cnt
  import gs_pkg::*;
#(
  parameter int W_LOG2 = 8,
  parameter int H_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                adv_i,
  output logic [W_LOG2-1:0]   x_o,
  output logic [H_LOG2-1:0]   y_o,
  output logic signed [2:0]   dx_o,
  output logic signed [2:0]   dy_o,
  output logic [4:0]          tap_o,
  output logic                tap_last_o,
  output logic                frame_last_o
);

  localparam logic signed [2:0] D_MIN = 3'(-KRAD);
  localparam logic signed [2:0] D_MAX = 3'(KRAD);
  localparam logic [W_LOG2-1:0] X_MAX = '1;
  localparam logic [H_LOG2-1:0] Y_MAX = '1;

  logic [W_LOG2-1:0] x_q, x_d;
  logic [H_LOG2-1:0] y_q, y_d;
  logic signed [2:0] dx_q, dx_d;
  logic signed [2:0] dy_q, dy_d;
  logic [4:0]        tap_q, tap_d;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    tap_d = tap_q;
    if (clr_i) begin
      x_d   = '0;
      y_d   = '0;
      dx_d  = D_MIN;
      dy_d  = D_MIN;
      tap_d = '0;
    end else if (adv_i) begin
      if (dx_q != D_MAX) begin
        dx_d  = dx_q + 3'sd1;
        tap_d = tap_q + 5'd1;
      end else begin
        dx_d = D_MIN;
        if (dy_q != D_MAX) begin
          dy_d  = dy_q + 3'sd1;
          tap_d = tap_q + 5'd1;
        end else begin
          // Window complete: move to the next output pixel.
          dy_d  = D_MIN;
          tap_d = '0;
          if (x_q != X_MAX) begin
            x_d = x_q + W_LOG2'(1);
          end else begin
            x_d = '0;
            y_d = y_q + H_LOG2'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
      tap_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      tap_q <= tap_d;
    end
  end

  assign x_o          = x_q;
  assign y_o          = y_q;
  assign dx_o         = dx_q;
  assign dy_o         = dy_q;
  assign tap_o        = tap_q;
  assign tap_last_o   = (dx_q == D_MAX) && (dy_q == D_MAX);
  assign frame_last_o = tap_last_o && (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/gs_win_fetch.sv
// Raster-order 5x5 neighbourhood read sequencer with clamped borders and tagged tap return.
// Handshake: a read is issued in every cycle rd_en=1; its byte returns exactly one cycle later
// on rd_valid and is forwarded as a tap. hold only blocks new issue, so one tap may follow it.
module gs_win_fetch
  import gs_pkg::*;
#(
  parameter int W_LOG2 = 8,
  parameter int H_LOG2 = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              hold,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [7:0]        rd_data,
  output logic              tap_valid,
  output logic [7:0]        tap_data,
  output logic [4:0]        tap_idx,
  output logic              tap_last,
  output logic [W_LOG2-1:0] pix_x,
  output logic [H_LOG2-1:0] pix_y,
  output logic              frame_last,
  output logic              busy,
  output logic              done,
  output gs_state_e         dbg_state
);

  localparam int W   = 1 << W_LOG2;
  localparam int H   = 1 << H_LOG2;
  localparam int SXW = W_LOG2 + 2;
  localparam int SYW = H_LOG2 + 2;

  gs_state_e state_q, state_d;
  logic      abort_q, abort_d;
  logic      cnt_clr, cnt_adv;

  logic [W_LOG2-1:0] cnt_x;
  logic [H_LOG2-1:0] cnt_y;
  logic signed [2:0] cnt_dx, cnt_dy;
  logic [4:0]        cnt_tap;
  logic              cnt_tap_last, cnt_frame_last;

  gs_win_cnt #(
    .W_LOG2(W_LOG2),
    .H_LOG2(H_LOG2)
  ) u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (cnt_clr),
    .adv_i        (cnt_adv),
    .x_o          (cnt_x),
    .y_o          (cnt_y),
    .dx_o         (cnt_dx),
    .dy_o         (cnt_dy),
    .tap_o        (cnt_tap),
    .tap_last_o   (cnt_tap_last),
    .frame_last_o (cnt_frame_last)
  );

  // Sums are two bits wider than the image so -2 and W+1 stay distinct before clamping.
  logic signed [SXW-1:0] sx;
  logic signed [SYW-1:0] sy;
  logic [W_LOG2-1:0]     xc;
  logic [H_LOG2-1:0]     yc;

  assign sx = $signed({2'b00, cnt_x}) + SXW'(cnt_dx);
  assign sy = $signed({2'b00, cnt_y}) + SYW'(cnt_dy);
  assign xc = W_LOG2'(gs_clamp(int'(sx), W - 1));
  assign yc = H_LOG2'(gs_clamp(int'(sy), H - 1));

  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    cnt_clr = 1'b0;
    cnt_adv = 1'b0;
    rd_en   = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          abort_d = 1'b0;
          cnt_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_FLUSH;
          abort_d = 1'b1;
        end else if (!hold) begin
          rd_en   = 1'b1;
          cnt_adv = 1'b1;
          if (cnt_frame_last) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
        done    = !abort_q && !abort;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
    end
  end

  // Tap metadata travels one cycle behind the read so it lines up with rd_valid.
  logic              inflight_q;
  logic [4:0]        tap_idx_q;
  logic [W_LOG2-1:0] pix_x_q;
  logic [H_LOG2-1:0] pix_y_q;
  logic              tap_last_q, frame_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q   <= 1'b0;
      tap_idx_q    <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      tap_last_q   <= 1'b0;
      frame_last_q <= 1'b0;
    end else begin
      inflight_q   <= rd_en;
      tap_last_q   <= rd_en && cnt_tap_last;
      frame_last_q <= rd_en && cnt_frame_last;
      if (rd_en) begin
        tap_idx_q <= cnt_tap;
        pix_x_q   <= cnt_x;
        pix_y_q   <= cnt_y;
      end
    end
  end

  // A return not matched by our own issue (e.g. one launched before reset) is dropped.
  assign tap_valid  = rd_valid && inflight_q;
  assign tap_data   = tap_valid ? rd_data : 8'd0;
  assign tap_idx    = tap_idx_q;
  assign tap_last   = tap_last_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign frame_last = frame_last_q;
  assign rd_addr    = rd_en ? ADDR_W'({yc, xc}) : '0;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_gs_win_fetch.sv
// Directed bench for gs_win_fetch on a 4x4 image with mem[a]=a.
module tb_gs_win_fetch;
  import gs_pkg::*;

  localparam int WL = 2;
  localparam int HL = 2;
  localparam int AW = 16;
  localparam int RW = 19;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, abort = 1'b0, hold = 1'b0;
  logic rd_en;
  logic [AW-1:0] rd_addr;
  logic rd_valid_m = 1'b0, stale_inj = 1'b0, rd_valid;
  logic [7:0] rd_data_m = 8'd0;
  logic tap_valid, tap_last, frame_last, busy, done;
  logic [7:0] tap_data;
  logic [4:0] tap_idx;
  logic [WL-1:0] pix_x;
  logic [HL-1:0] pix_y;
  gs_state_e dbg_state;

  assign rd_valid = rd_valid_m | stale_inj;

  always @(posedge clk) begin
    rd_valid_m <= rd_en;
    rd_data_m  <= rd_addr[7:0];
  end

  gs_win_fetch #(.W_LOG2(WL), .H_LOG2(HL), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data_m),
    .tap_valid(tap_valid), .tap_data(tap_data), .tap_idx(tap_idx), .tap_last(tap_last),
    .pix_x(pix_x), .pix_y(pix_y), .frame_last(frame_last), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // scoreboard state
  int tests = 0, fails = 0;
  int cyc = 0, rd_cnt = 0, tap_cnt = 0, done_cnt = 0, flast_cnt = 0;
  int last_rd_cyc = 0, flast_cyc = 0, done_cyc = 0;
  logic busy_after = 1'b1, prev_done = 1'b0;
  int addr_log [400];
  int m_x = 0, m_y = 0, m_t = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int model_addr(input int x, input int y, input int t);
    int dx, dy;
    dx = (t % 5) - 2;
    dy = (t / 5) - 2;
    return clampi(y + dy, 3) * 4 + clampi(x + dx, 3);
  endfunction

  function automatic logic [RW-1:0] mk_rec(input int d, input int t, input int x, input int y);
    logic [7:0] d8;
    logic [4:0] t5;
    logic [1:0] x2, y2;
    logic tl, fl;
    d8 = d[7:0];
    t5 = t[4:0];
    x2 = x[1:0];
    y2 = y[1:0];
    tl = (t == 24);
    fl = (t == 24) && (x == 3) && (y == 3);
    return {d8, t5, x2, y2, tl, fl};
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    int a;
    logic [RW-1:0] rec;
    if (rst_n) begin
      if (tap_valid) begin
        tap_cnt++;
        if (exp_q.size() == 0) begin
          check("tap_unexpected", 32'(tap_valid), 32'd0);
        end else begin
          rec = exp_q.pop_front();
          check("tap_rec", 32'({tap_data, tap_idx, pix_x, pix_y, tap_last, frame_last}), 32'(rec));
        end
      end
      if (frame_last) begin
        flast_cnt++;
        flast_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_done) busy_after = busy;
      prev_done = done;
      if (rd_en) begin
        a = model_addr(m_x, m_y, m_t);
        check("rd_addr", 32'(rd_addr), 32'(a));
        if (rd_cnt < 400) addr_log[rd_cnt] = int'(rd_addr);
        exp_q.push_back(mk_rec(a, m_t, m_x, m_y));
        rd_cnt++;
        last_rd_cyc = cyc;
        m_t++;
        if (m_t == 25) begin
          m_t = 0;
          m_x++;
          if (m_x == 4) begin
            m_x = 0;
            m_y = (m_y + 1) % 4;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    m_x = 0; m_y = 0; m_t = 0;
    rd_cnt = 0; tap_cnt = 0; done_cnt = 0; flast_cnt = 0;
    prev_done = 1'b0; busy_after = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_reads(input int n);
    for (int i = 0; i < 2000 && rd_cnt < n; i++) tick();
    check("wait_reads_budget", 32'(rd_cnt), 32'(n));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000 && done_cnt == 0; i++) tick();
    tick();
    tick();
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_reads"}, 32'(rd_cnt), 32'd400);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_flast_cnt"}, 32'(flast_cnt), 32'd1);
    check({tag, "_flast_cyc"}, 32'(flast_cyc), 32'(last_rd_cyc + 1));
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(flast_cyc));
    check({tag, "_busy_after"}, 32'(busy_after), 32'd0);
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  int first25 [25] = '{0,0,0,1,2, 0,0,0,1,2, 0,0,0,1,2, 4,4,4,5,6, 8,8,8,9,10};
  int last25  [25] = '{5,6,7,7,7, 9,10,11,11,11, 13,14,15,15,15, 13,14,15,15,15, 13,14,15,15,15};

  initial begin
    int r0, t0;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_tap_valid", 32'(tap_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // full frame
    do_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_rd_en", 32'(rd_en), 32'd1);
    wait_done();
    check_frame("full");
    for (int i = 0; i < 25; i++) check($sformatf("first_addr%0d", i), 32'(addr_log[i]), 32'(first25[i]));
    for (int i = 0; i < 25; i++) check($sformatf("last_addr%0d", i), 32'(addr_log[375 + i]), 32'(last25[i]));
    check("idle_busy", 32'(busy), 32'd0);

    // hold after tap 7 of pixel (1,0)
    do_start();
    wait_reads(33);
    check("hold_tap7_addr", 32'(addr_log[32]), 32'd1);
    hold = 1'b1;
    r0 = rd_cnt;
    t0 = tap_cnt;
    tick(); tick(); tick();
    hold = 1'b0;
    check("hold_no_reads", 32'(rd_cnt - r0), 32'd0);
    check("hold_one_tap", 32'(tap_cnt - t0), 32'd1);
    wait_done();
    check("hold_tap8_addr", 32'(addr_log[33]), 32'd2);
    check_frame("hold");

    // start while busy is ignored
    do_start();
    wait_reads(100);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    check_frame("start_busy");

    // abort at read 50
    do_start();
    wait_reads(50);
    abort = 1'b1;
    @(negedge clk);
    check("abort_no_rd", 32'(rd_en), 32'd0);
    check("abort_inflight", 32'(tap_valid), 32'd1);
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    check("abort_done", 32'(done_cnt), 32'd0);
    check("abort_reads", 32'(rd_cnt), 32'd50);
    check("abort_flast", 32'(flast_cnt), 32'd0);
    check("abort_q_empty", 32'(exp_q.size()), 32'd0);
    do_start();
    check("abort_restart_en", 32'(rd_en), 32'd1);
    check("abort_restart_addr", 32'(rd_addr), 32'd0);
    wait_done();
    check_frame("after_abort");

    // asynchronous reset mid-frame
    do_start();
    wait_reads(200);
    rst_n = 1'b0;
    #1;
    check("mrst_rd_en", 32'(rd_en), 32'd0);
    check("mrst_rd_addr", 32'(rd_addr), 32'd0);
    check("mrst_tap_valid", 32'(tap_valid), 32'd0);
    check("mrst_tap_data", 32'(tap_data), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_tap_idx", 32'(tap_idx), 32'd0);
    check("mrst_pix", 32'({pix_x, pix_y}), 32'd0);
    check("mrst_last", 32'({tap_last, frame_last}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    stale_inj = 1'b1;
    #2;
    check("stale_valid", 32'(tap_valid), 32'd0);
    tick();
    stale_inj = 1'b0;
    do_start();
    wait_done();
    check_frame("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
